// File: rtl/ysyx_23060208_idu.sv
// RV32I decode stage: one registered output slot between fetch and EXU,
// pass-through ready, EXU flush, and a wrapping delivered-instruction count.
module ysyx_23060208_idu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] ifu_to_idu_data_i,
    input  logic                    ifu_to_idu_valid,
    output logic                    idu_to_ifu_ready,
    input  logic                    flush,
    output logic                    idu_to_exu_valid,
    input  logic                    exu_to_idu_ready,
    output logic [DATA_WIDTH-1:0]   idu_pc,
    output logic [DATA_WIDTH-1:0]   idu_inst,
    output logic [31:0]             idu_imm,
    output logic [4:0]              idu_rs1,
    output logic [4:0]              idu_rs2,
    output logic [4:0]              idu_rd,
    output logic [2:0]              idu_funct3,
    output logic                    idu_funct7b5,
    output logic [3:0]              idu_opclass,
    output logic                    idu_rf_wen,
    output logic                    idu_illegal,
    output logic [31:0]             idu_inst_cnt
);
    logic [DATA_WIDTH-1:0] pc, inst;
    assign pc   = ifu_to_idu_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign inst = ifu_to_idu_data_i[DATA_WIDTH-1:0];

    logic accept, drain;
    assign idu_to_ifu_ready = !flush & (!idu_to_exu_valid | exu_to_idu_ready);
    assign accept = ifu_to_idu_valid & idu_to_ifu_ready;
    assign drain  = idu_to_exu_valid & exu_to_idu_ready;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic [3:0]  opclass_d;
    logic [31:0] imm_d;
    logic        wen_d, ill_d;

    // Full 7-bit opcode match also rejects compressed encodings (inst[1:0]!=11).
    always_comb begin
        opclass_d = 4'd15;
        imm_d     = '0;
        wen_d     = 1'b0;
        ill_d     = 1'b0;
        case (inst[6:0])
            7'b0110111: begin opclass_d = 4'd0;  imm_d = imm_u; wen_d = 1'b1; end
            7'b0010111: begin opclass_d = 4'd1;  imm_d = imm_u; wen_d = 1'b1; end
            7'b1101111: begin opclass_d = 4'd2;  imm_d = imm_j; wen_d = 1'b1; end
            7'b1100111: begin opclass_d = 4'd3;  imm_d = imm_i; wen_d = 1'b1; end
            7'b1100011: begin opclass_d = 4'd4;  imm_d = imm_b; end
            7'b0000011: begin opclass_d = 4'd5;  imm_d = imm_i; wen_d = 1'b1; end
            7'b0100011: begin opclass_d = 4'd6;  imm_d = imm_s; end
            7'b0010011: begin opclass_d = 4'd7;  imm_d = imm_i; wen_d = 1'b1; end
            7'b0110011: begin opclass_d = 4'd8;  wen_d = 1'b1; end
            7'b1110011: begin opclass_d = 4'd9;  imm_d = imm_i; wen_d = (inst[14:12] != 3'd0); end
            7'b0001111: begin opclass_d = 4'd10; imm_d = imm_i; end
            default:    ill_d = 1'b1;
        endcase
        wen_d = wen_d & (inst[11:7] != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idu_to_exu_valid <= 1'b0;
            idu_pc           <= '0;
            idu_inst         <= '0;
            idu_imm          <= '0;
            idu_rs1          <= '0;
            idu_rs2          <= '0;
            idu_rd           <= '0;
            idu_funct3       <= '0;
            idu_funct7b5     <= 1'b0;
            idu_opclass      <= '0;
            idu_rf_wen       <= 1'b0;
            idu_illegal      <= 1'b0;
            idu_inst_cnt     <= '0;
        end else begin
            if (accept) begin
                idu_to_exu_valid <= 1'b1;
                idu_pc           <= pc;
                idu_inst         <= inst;
                idu_imm          <= imm_d;
                idu_rs1          <= inst[19:15];
                idu_rs2          <= inst[24:20];
                idu_rd           <= inst[11:7];
                idu_funct3       <= inst[14:12];
                idu_funct7b5     <= inst[30];
                idu_opclass      <= opclass_d;
                idu_rf_wen       <= wen_d;
                idu_illegal      <= ill_d;
            end else if (drain || flush) begin
                idu_to_exu_valid <= 1'b0;
            end
            if (drain)
                idu_inst_cnt <= idu_inst_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_ysyx_23060208_idu.sv
// Scoreboard bench for the decode stage: accepted bundles are modelled and
// queued, then compared field by field when EXU takes them.
module tb_ysyx_23060208_idu;
    logic        clk = 1'b0, clk_en = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] ifu_to_idu_data_i = '0;
    logic        ifu_to_idu_valid = 1'b0, flush = 1'b0, exu_to_idu_ready = 1'b0;
    logic        idu_to_ifu_ready, idu_to_exu_valid, idu_funct7b5, idu_rf_wen, idu_illegal;
    logic [31:0] idu_pc, idu_inst, idu_imm, idu_inst_cnt;
    logic [4:0]  idu_rs1, idu_rs2, idu_rd;
    logic [2:0]  idu_funct3;
    logic [3:0]  idu_opclass;

    ysyx_23060208_idu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ifu_to_idu_data_i(ifu_to_idu_data_i),
        .ifu_to_idu_valid(ifu_to_idu_valid), .idu_to_ifu_ready(idu_to_ifu_ready),
        .flush(flush), .idu_to_exu_valid(idu_to_exu_valid), .exu_to_idu_ready(exu_to_idu_ready),
        .idu_pc(idu_pc), .idu_inst(idu_inst), .idu_imm(idu_imm), .idu_rs1(idu_rs1),
        .idu_rs2(idu_rs2), .idu_rd(idu_rd), .idu_funct3(idu_funct3), .idu_funct7b5(idu_funct7b5),
        .idu_opclass(idu_opclass), .idu_rf_wen(idu_rf_wen), .idu_illegal(idu_illegal),
        .idu_inst_cnt(idu_inst_cnt)
    );

    always begin #5; if (clk_en) clk = ~clk; end

    typedef struct packed {
        logic [31:0] pc, inst, imm;
        logic [3:0]  opclass;
        logic        wen, ill;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] i);
        exp_t e;
        logic [31:0] ii, is, ib, iu, ij;
        ii = 32'($signed(i[31:20]));
        is = 32'($signed({i[31:25], i[11:7]}));
        ib = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        iu = {i[31:12], 12'h000};
        ij = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        e.pc = pc; e.inst = i; e.ill = 1'b0;
        case (i[6:0])
            7'h37: begin e.opclass = 0;  e.imm = iu; e.wen = 1; end
            7'h17: begin e.opclass = 1;  e.imm = iu; e.wen = 1; end
            7'h6F: begin e.opclass = 2;  e.imm = ij; e.wen = 1; end
            7'h67: begin e.opclass = 3;  e.imm = ii; e.wen = 1; end
            7'h63: begin e.opclass = 4;  e.imm = ib; e.wen = 0; end
            7'h03: begin e.opclass = 5;  e.imm = ii; e.wen = 1; end
            7'h23: begin e.opclass = 6;  e.imm = is; e.wen = 0; end
            7'h13: begin e.opclass = 7;  e.imm = ii; e.wen = 1; end
            7'h33: begin e.opclass = 8;  e.imm = 0;  e.wen = 1; end
            7'h73: begin e.opclass = 9;  e.imm = ii; e.wen = (i[14:12] != 0); end
            7'h0F: begin e.opclass = 10; e.imm = ii; e.wen = 0; end
            default: begin e.opclass = 15; e.imm = 0; e.wen = 0; e.ill = 1; end
        endcase
        if (i[11:7] == 0) e.wen = 0;
        return e;
    endfunction

    // Drain before accept: the item leaving is always older than one arriving.
    always @(negedge clk) begin
        if (!rst) begin
            if (idu_to_exu_valid && exu_to_idu_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pc", idu_pc, e.pc);
                    chk("inst", idu_inst, e.inst);
                    chk("imm", idu_imm, e.imm);
                    chk("rs1", 32'(idu_rs1), 32'(e.inst[19:15]));
                    chk("rs2", 32'(idu_rs2), 32'(e.inst[24:20]));
                    chk("rd", 32'(idu_rd), 32'(e.inst[11:7]));
                    chk("funct3", 32'(idu_funct3), 32'(e.inst[14:12]));
                    chk("funct7b5", 32'(idu_funct7b5), 32'(e.inst[30]));
                    chk("opclass", 32'(idu_opclass), 32'(e.opclass));
                    chk("rf_wen", 32'(idu_rf_wen), 32'(e.wen));
                    chk("illegal", 32'(idu_illegal), 32'(e.ill));
                end
            end
            if (ifu_to_idu_valid && idu_to_ifu_ready && !flush)
                sb.push_back(model(ifu_to_idu_data_i[63:32], ifu_to_idu_data_i[31:0]));
        end
    end

    task automatic present(input logic [31:0] pc, input logic [31:0] i);
        ifu_to_idu_data_i = {pc, i};
        ifu_to_idu_valid  = 1'b1;
    endtask

    // Hold the bundle until taken; returns just after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] i);
        int n;
        present(pc, i);
        n = 0;
        do begin @(negedge clk); n++; end while (!idu_to_ifu_ready && n < 50);
        if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ifu_to_idu_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [31:0] stream [8] = '{32'h123450B7, 32'h00001117, 32'h008000EF, 32'h000080E7,
                                32'h0040A183, 32'h0030A223, 32'h40208233, 32'h300022F3};

    initial begin
        #1 rst = 1'b1;
        #4;
        chk("rst_valid", 32'(idu_to_exu_valid), 32'd0);
        chk("rst_cnt", idu_inst_cnt, 32'd0);
        chk("rst_imm", idu_imm, 32'd0);
        chk("rst_opclass", 32'(idu_opclass), 32'd0);
        chk("rst_illegal", 32'(idu_illegal), 32'd0);
        rst = 1'b0; #1;
        chk("rst_ready", 32'(idu_to_ifu_ready), 32'd1);
        clk_en = 1'b1;
        step();

        // addi x1,x0,5
        exu_to_idu_ready = 1'b1;
        send(32'h80000000, 32'h00500093);
        chk("addi_valid", 32'(idu_to_exu_valid), 32'd1);
        chk("addi_opclass", 32'(idu_opclass), 32'd7);
        chk("addi_rd", 32'(idu_rd), 32'd1);
        chk("addi_rs1", 32'(idu_rs1), 32'd0);
        chk("addi_imm", idu_imm, 32'h00000005);
        chk("addi_wen", 32'(idu_rf_wen), 32'd1);
        step();
        chk("cnt_1", idu_inst_cnt, 32'd1);
        chk("drained", 32'(idu_to_exu_valid), 32'd0);

        // backpressure: addi sp,sp,-32 held while a second bundle waits
        exu_to_idu_ready = 1'b0;
        send(32'h80000004, 32'hFE010113);
        present(32'h80000008, 32'h00A00093);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(idu_to_ifu_ready), 32'd0);
            chk("bp_imm", idu_imm, 32'hFFFFFFE0);
            chk("bp_pc", idu_pc, 32'h80000004);
        end
        step();
        exu_to_idu_ready = 1'b1;
        step();
        ifu_to_idu_valid = 1'b0;
        chk("bp_next_valid", 32'(idu_to_exu_valid), 32'd1);
        chk("bp_next_pc", idu_pc, 32'h80000008);
        step();
        chk("cnt_3", idu_inst_cnt, 32'd3);

        // beq x0,x0,-4 then addi x0,x0,0
        send(32'h8000000C, 32'hFE000EE3);
        chk("beq_opclass", 32'(idu_opclass), 32'd4);
        chk("beq_imm", idu_imm, 32'hFFFFFFFC);
        chk("beq_wen", 32'(idu_rf_wen), 32'd0);
        send(32'h80000010, 32'h00000013);
        chk("nop_wen", 32'(idu_rf_wen), 32'd0);
        step();
        chk("cnt_5", idu_inst_cnt, 32'd5);

        // flush kills the held instruction and drops the incoming one
        exu_to_idu_ready = 1'b0;
        send(32'h80000014, 32'h00100113);
        present(32'h80000018, 32'h00200193);
        flush = 1'b1; #1;
        chk("flush_ready", 32'(idu_to_ifu_ready), 32'd0);
        step();
        flush = 1'b0;
        ifu_to_idu_valid = 1'b0;
        chk("flush_valid", 32'(idu_to_exu_valid), 32'd0);
        chk("flush_cnt", idu_inst_cnt, 32'd5);
        chk("flush_sb", 32'(sb.size()), 32'd1);
        sb.delete();

        // illegal encodings and fence
        exu_to_idu_ready = 1'b1;
        send(32'h8000001C, 32'h00000000);
        chk("ill_flag", 32'(idu_illegal), 32'd1);
        chk("ill_opclass", 32'(idu_opclass), 32'd15);
        chk("ill_wen", 32'(idu_rf_wen), 32'd0);
        chk("ill_imm", idu_imm, 32'd0);
        send(32'h80000020, 32'h0000007F);
        send(32'h80000024, 32'h0FF0000F);
        chk("fence_opclass", 32'(idu_opclass), 32'd10);
        step();
        chk("cnt_8", idu_inst_cnt, 32'd8);

        // full-rate stream of 8
        for (int k = 0; k < 8; k++) begin
            present(32'h80000100 + 32'(4 * k), stream[k]);
            @(negedge clk);
            chk("stream_ready", 32'(idu_to_ifu_ready), 32'd1);
            if (k > 0) chk("stream_valid", 32'(idu_to_exu_valid), 32'd1);
            step();
        end
        ifu_to_idu_valid = 1'b0;
        step();
        chk("cnt_16", idu_inst_cnt, 32'd16);

        // async reset while an instruction is held
        exu_to_idu_ready = 1'b0;
        send(32'h80000200, 32'hFE010113);
        #2 rst = 1'b1; #1;
        chk("midrst_valid", 32'(idu_to_exu_valid), 32'd0);
        chk("midrst_cnt", idu_inst_cnt, 32'd0);
        chk("midrst_imm", idu_imm, 32'd0);
        sb.delete();
        step();
        rst = 1'b0;
        step();
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
